// File: rtl/ace_snoop_resp_ctrl_if.sv
// ACE snoop channel bundle: AC request, CR response, CD data.
// Master drives AC and the CR/CD ready lines; slave answers.
interface ace_snoop_resp_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              acvalid;
  logic              acready;
  logic [ADDR_W-1:0] acaddr;
  logic [3:0]        acsnoop;
  logic              crvalid;
  logic              crready;
  logic [4:0]        crresp;
  logic              cdvalid;
  logic              cdready;
  logic [DATA_W-1:0] cddata;
  logic              cdlast;

  modport master (
    output acvalid, acaddr, acsnoop,
    output crready, cdready,
    input  acready, crvalid, crresp,
    input  cdvalid, cddata, cdlast
  );

  modport slave (
    input  acvalid, acaddr, acsnoop,
    input  crready, cdready,
    output acready, crvalid, crresp,
    output cdvalid, cddata, cdlast
  );
endinterface

// File: rtl/ace_snoop_resp_ctrl.sv
// Snoop front end: one snoop at a time, CR response then CD beats,
// line data buffered in LOOKUP before the coherence FSM moves.
module ace_snoop_resp_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int LINE_OFF = 6,
  parameter int DATA_W   = 64,
  parameter int BEATS    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ace_snoop_resp_ctrl_if.slave    snp,
  input  logic [ADDR_W-1:0]       line_addr,
  input  logic                    line_invalid,
  input  logic                    line_unique_clean,
  input  logic                    line_unique_dirty,
  input  logic [DATA_W*BEATS-1:0] line_data,
  output logic [1:0]              fsm_snoop_op
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam int TW = ADDR_W - LINE_OFF;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESP,
    DATA
  } state_t;

  state_t state, state_n;

  logic [TW-1:0]           tag_q;
  logic [3:0]              snoop_q;
  logic [4:0]              resp_q;
  logic [BW-1:0]           beat;
  logic [DATA_W*BEATS-1:0] buffer;

  logic       hit;
  logic [4:0] resp_lu;
  logic [1:0] op_lu;
  logic       unused_ok;

  // INVALID is implied by neither unique bit being set
  assign unused_ok = ^{line_invalid, snp.acaddr[LINE_OFF-1:0]};

  assign hit = (tag_q == line_addr[ADDR_W-1:LINE_OFF])
             && (line_unique_clean || line_unique_dirty);

  always_comb begin
    resp_lu = 5'b00000;
    op_lu   = 2'b00;
    case (snoop_q)
      4'b0000: begin
        if (hit) resp_lu = 5'b10001;
      end
      4'b0001, 4'b0010, 4'b0011,
      4'b0111, 4'b1001: begin
        if (hit) begin
          op_lu   = 2'b01;
          resp_lu = {2'b10, line_unique_dirty, 2'b01};
        end
      end
      4'b1000: begin
        if (hit && line_unique_dirty) begin
          op_lu   = 2'b10;
          resp_lu = 5'b10101;
        end else if (hit) begin
          resp_lu = 5'b10000;
        end
      end
      4'b1101: begin
        if (hit) begin
          op_lu   = 2'b01;
          resp_lu = 5'b10000;
        end
      end
      default: resp_lu = 5'b00010;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    snp.acready  = 1'b0;
    snp.crvalid  = 1'b0;
    snp.cdvalid  = 1'b0;
    snp.cdlast   = 1'b0;
    snp.cddata   = '0;
    fsm_snoop_op = 2'b00;
    unique case (state)
      IDLE: begin
        snp.acready = !rst;
        if (snp.acvalid && !rst) state_n = LOOKUP;
      end
      LOOKUP: begin
        fsm_snoop_op = rst ? 2'b00 : op_lu;
        state_n      = RESP;
      end
      RESP: begin
        snp.crvalid = 1'b1;
        if (snp.crready)
          state_n = resp_q[0] ? DATA : IDLE;
      end
      DATA: begin
        snp.cdvalid = 1'b1;
        snp.cddata  = buffer[int'(beat)*DATA_W +: DATA_W];
        snp.cdlast  = (beat == LAST);
        if (snp.cdready && snp.cdlast) state_n = IDLE;
      end
    endcase
  end

  assign snp.crresp = resp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      snoop_q <= '0;
      resp_q  <= '0;
      beat    <= '0;
      buffer  <= '0;
    end else begin
      if (state == IDLE && snp.acvalid) begin
        tag_q   <= snp.acaddr[ADDR_W-1:LINE_OFF];
        snoop_q <= snp.acsnoop;
      end
      if (state == LOOKUP) begin
        resp_q <= resp_lu;
        buffer <= line_data;
      end
      if (state == DATA && snp.cdready)
        beat <= snp.cdlast ? '0 : beat + 1'b1;
    end
  end

endmodule
